// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS-I subset core.
// One shared ALU and one req/ready memory port for code and data.
module mips_multicycle_core #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned ZERO_REGS = 1
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [31:0]       pc_out,
   output logic [31:0]       inst_out,
   output logic [31:0]       alu_out,
   output logic [2:0]        state_out,
   output logic              halted
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] ir_q, ir_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] alu_q, alu_d;
   logic [31:0] mdr_q, mdr_d;

   logic [31:0] rf_q [32];
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   logic [5:0]  opcode;
   logic [5:0]  funct;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] simm;
   logic [31:0] rs_val;
   logic [31:0] rt_val;

   alu_op_t     r_op;
   logic        r_ok;
   alu_op_t     alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_y;
   logic [31:0] addr32;

   assign opcode = ir_q[31:26];
   assign rs     = ir_q[25:21];
   assign rt     = ir_q[20:16];
   assign rd     = ir_q[15:11];
   assign funct  = ir_q[5:0];
   assign simm   = {{16{ir_q[15]}}, ir_q[15:0]};

   // r0 is hardwired to zero whatever the array holds
   assign rs_val = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rt_val = (rt == 5'd0) ? 32'd0 : rf_q[rt];

   // R-type funct decode; unknown funct flags an illegal instruction
   always_comb begin
      r_op = ALU_ADD;
      r_ok = 1'b1;
      case (funct)
         FN_ADD:  r_op = ALU_ADD;
         FN_SUB:  r_op = ALU_SUB;
         FN_AND:  r_op = ALU_AND;
         FN_OR:   r_op = ALU_OR;
         FN_SLT:  r_op = ALU_SLT;
         default: r_ok = 1'b0;
      endcase
   end

   // ALU operand steering: pc+4 in FETCH, branch target in DECODE
   always_comb begin
      alu_a  = pc_q;
      alu_b  = 32'd4;
      alu_op = ALU_ADD;
      case (state_q)
         S_DECODE: alu_b = {simm[29:0], 2'b00};
         S_EXEC: begin
            alu_a = a_q;
            case (opcode)
               OP_R: begin
                  alu_b  = b_q;
                  alu_op = r_op;
               end
               OP_BEQ: begin
                  alu_b  = b_q;
                  alu_op = ALU_SUB;
               end
               default: alu_b = simm;
            endcase
         end
         default: ;
      endcase
   end

   // the single shared ALU
   always_comb begin
      alu_y = 32'd0;
      case (alu_op)
         ALU_ADD: alu_y = alu_a + alu_b;
         ALU_SUB: alu_y = alu_a - alu_b;
         ALU_AND: alu_y = alu_a & alu_b;
         ALU_OR:  alu_y = alu_a | alu_b;
         ALU_SLT: alu_y = {31'd0, $signed(alu_a) < $signed(alu_b)};
         default: alu_y = 32'd0;
      endcase
   end

   // next-state and datapath register updates per FSM state
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      a_d      = a_q;
      b_d      = b_q;
      alu_d    = alu_q;
      mdr_d    = mdr_q;
      rf_we    = 1'b0;
      rf_waddr = rt;
      rf_wdata = mdr_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready) begin
               ir_d    = mem_rdata;
               pc_d    = alu_y;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            a_d   = rs_val;
            b_d   = rt_val;
            alu_d = alu_y;
            case (opcode)
               OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ: state_d = S_EXEC;
               OP_J: begin
                  pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                  state_d = S_FETCH;
               end
               default: state_d = S_HALT;
            endcase
         end
         S_EXEC: begin
            case (opcode)
               OP_R: begin
                  if (r_ok) begin
                     alu_d   = alu_y;
                     state_d = S_WB;
                  end else begin
                     state_d = S_HALT;
                  end
               end
               OP_BEQ: begin
                  if (alu_y == 32'd0) pc_d = alu_q;
                  state_d = S_FETCH;
               end
               OP_LW, OP_SW: begin
                  alu_d   = alu_y;
                  state_d = S_MEM;
               end
               default: begin
                  alu_d   = alu_y;
                  state_d = S_WB;
               end
            endcase
         end
         S_MEM: begin
            if (mem_ready) begin
               if (opcode == OP_LW) begin
                  mdr_d   = mem_rdata;
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_WB: begin
            rf_we = 1'b1;
            case (opcode)
               OP_R: begin
                  rf_waddr = rd;
                  rf_wdata = alu_q;
               end
               OP_ADDI: rf_wdata = alu_q;
               default: rf_wdata = mdr_q;
            endcase
            state_d = S_FETCH;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         ir_q    <= 32'd0;
         a_q     <= 32'd0;
         b_q     <= 32'd0;
         alu_q   <= 32'd0;
         mdr_q   <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         a_q     <= a_d;
         b_q     <= b_d;
         alu_q   <= alu_d;
         mdr_q   <= mdr_d;
      end
   end

   // register file; reset aborts any pending write-back
   always_ff @(posedge clk) begin
      if (reset) begin
         if (ZERO_REGS != 0) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
         end
      end else if (rf_we && (rf_waddr != 5'd0)) begin
         rf_q[rf_waddr] <= rf_wdata;
      end
   end

   assign addr32    = (state_q == S_MEM) ? alu_q : pc_q;
   assign mem_addr  = addr32[ADDR_W-1:0];
   assign mem_wdata = b_q;
   assign mem_req   = !reset &&
                      ((state_q == S_FETCH) || (state_q == S_MEM));
   assign mem_we    = !reset && (state_q == S_MEM) && (opcode == OP_SW);
   assign pc_out    = pc_q;
   assign inst_out  = ir_q;
   assign alu_out   = alu_q;
   assign state_out = state_q;
   assign halted    = (state_q == S_HALT);

endmodule
